// File: rtl/booth_mult_param_if.sv
// -----------------------------------------------------------------------------
// booth_mult_param_if
// Request/response bundle for the Booth multiplier.
//   start       : request a multiply (master -> slave)
//   signed_mode : 1 = two's-complement operands, 0 = unsigned
//   mcd, multi  : multiplicand / multiplier, WIDTH bits each
//   prod        : registered 2*WIDTH-bit product (slave -> master)
//   busy        : operation in progress
//   done        : one-cycle pulse when prod is updated
// -----------------------------------------------------------------------------
interface booth_mult_param_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     mcd;
  logic [WIDTH-1:0]     multi;
  logic [2*WIDTH-1:0]   prod;
  logic                 busy;
  logic                 done;

  modport master (
    output start, signed_mode, mcd, multi,
    input  prod, busy, done
  );

  modport slave (
    input  start, signed_mode, mcd, multi,
    output prod, busy, done
  );
endinterface

// File: rtl/booth_mult_param.sv
// -----------------------------------------------------------------------------
// booth_mult_param
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// Operands are extended to WIDTH+1 bits so both modes share one signed datapath;
// WIDTH+1 iterations are run, giving a fixed latency of WIDTH+1 cycles from the
// accepting edge to the done pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : booth_mult_param_if.slave (start/signed_mode/mcd/multi in,
//          prod/busy/done out)
// -----------------------------------------------------------------------------
module booth_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  booth_mult_param_if.slave  bus
);

  localparam int XW = WIDTH + 1;            // extended operand width
  localparam int CW = $clog2(WIDTH + 2);    // counter must hold WIDTH+1

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       a_q, a_d;            // accumulator A
  logic [XW-1:0]       q_q, q_d;            // multiplier register Q
  logic [XW-1:0]       m_q, m_d;            // captured multiplicand M
  logic                qm1_q, qm1_d;        // Q(-1)
  logic [CW-1:0]       cnt_q, cnt_d;        // iterations remaining
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [XW-1:0]       a_sum;               // A after the Booth add/sub step

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    a_sum   = a_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // Zero-extension makes an unsigned operand a non-negative signed
          // one, so the signed Booth datapath covers both modes.
          m_d     = {bus.signed_mode & bus.mcd[WIDTH-1],   bus.mcd};
          q_d     = {bus.signed_mode & bus.multi[WIDTH-1], bus.multi};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(XW);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        case ({q_q[0], qm1_q})
          2'b01:   a_sum = a_q + m_q;
          2'b10:   a_sum = a_q - m_q;
          default: a_sum = a_q;
        endcase
        // Arithmetic shift of {A,Q,Q(-1)}: A's sign bit is replicated.
        a_d   = {a_sum[XW-1], a_sum[XW-1:1]};
        q_d   = {a_sum[0], q_q[XW-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Low 2*WIDTH bits of the final {A,Q}.
          prod_d  = {a_d[WIDTH-2:0], q_d};
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state, datapath registers included, is cleared by reset; the
    // block holds no memory arrays, so there is no cost to a full reset.
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.prod = prod_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
